// File: rtl/dpram_rd_check.sv
// Port-B read sweeper for the dual-port RAM demo: reads every address once after the
// writer finishes, checks each word against (addr + SEED), and reports errors and pass/fail.
module dpram_rd_check #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1,
  parameter int SEED   = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  state_e              state_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [1:0]          drain_q;
  logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_err_q, first_err_d;
  logic [RD_LAT-1:0]   vld_q;
  logic [ADDR_W-1:0]   addr_pipe_q [RD_LAT];

  logic                start;
  logic                cmp_valid;
  logic [ADDR_W-1:0]   cmp_addr;
  logic [DATA_W-1:0]   exp_word;
  logic                mismatch;

  assign start = (state_q == IDLE) && wr_done;

  // NOTE: registers update with <= so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      drain_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wr_done) begin
            state_q   <= READ;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
            pass_q    <= 1'b0;
          end
        end
        READ: begin
          if (rd_addr_q == LAST_ADDR) begin
            rd_en_q <= 1'b0;
            drain_q <= DRAIN_LAST;
            state_q <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (drain_q == 2'd0) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 2'd1;
          end
        end
        FIN: begin
          // The last compare closed in the previous cycle, so err_cnt_q is final here.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          pass_q  <= (err_cnt_q == '0);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valid bits follow each issued read through the RAM latency and are cleared by reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_q <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) vld_q[i] <= vld_q[i-1];
      vld_q[0] <= rd_en_q;
    end
  end

  // NOTE: the address delay line has no reset; its contents are ignored unless the matching valid bit is set.
  always_ff @(posedge sys_clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) addr_pipe_q[i] <= addr_pipe_q[i-1];
    addr_pipe_q[0] <= rd_addr_q;
  end

  assign cmp_valid = vld_q[RD_LAT-1];
  assign cmp_addr  = addr_pipe_q[RD_LAT-1];
  assign exp_word  = DATA_W'(cmp_addr) + DATA_W'(SEED);
  assign mismatch  = cmp_valid && (rd_data != exp_word);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    if (start) begin
      err_cnt_d   = '0;
      first_err_d = '0;
    end else if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
      if (err_cnt_q == '0) first_err_d = cmp_addr;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign rd_en          = rd_en_q;
  assign rd_addr        = rd_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_dpram_rd_check.sv
// Bench for dpram_rd_check: three configurations share one clock, each with a behavioural
// RAM; results are compared against a model that scans memory for words != (a + SEED).
module tb_dpram_rd_check;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       wr_done        [3];
  logic       rd_en          [3];
  logic [7:0] rd_addr        [3];
  logic [7:0] rd_data        [3];
  logic       busy           [3];
  logic       done           [3];
  logic       pass           [3];
  logic [8:0] err_cnt        [3];
  logic [7:0] first_err_addr [3];

  logic [7:0] mem [3][256];
  logic [7:0] p1  [3];
  logic [7:0] p2  [3];

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  function automatic int dep_of(input int d);
    case (d)
      0:       return 256;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int seed_of(input int d);
    case (d)
      0:       return 0;
      1:       return 'h5A;
      default: return 7;
    endcase
  endfunction

  dpram_rd_check #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .RD_LAT(1), .SEED(0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_done(wr_done[0]),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(err_cnt[0]), .first_err_addr(first_err_addr[0])
  );

  dpram_rd_check #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .RD_LAT(2), .SEED('h5A)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_done(wr_done[1]),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(err_cnt[1]), .first_err_addr(first_err_addr[1])
  );

  dpram_rd_check #(.ADDR_W(8), .DATA_W(8), .DEPTH(1), .RD_LAT(2), .SEED(7)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_done(wr_done[2]),
    .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_cnt(err_cnt[2]), .first_err_addr(first_err_addr[2])
  );

  // Behavioural RAM port B: first stage registers the read, second adds one more cycle.
  always @(posedge sys_clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rd_en[d]) p1[d] <= mem[d][rd_addr[d]];
      p2[d] <= p1[d];
    end
  end

  assign rd_data[0] = p1[0];
  assign rd_data[1] = p2[1];
  assign rd_data[2] = p2[2];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_mem(input int d);
    for (int a = 0; a < 256; a++) mem[d][a] = 8'(a + seed_of(d));
  endtask

  // Reference: count words that differ from (a + SEED) mod 256 over the swept range.
  task automatic model(input int d, output int exp_err, output int exp_first);
    exp_err   = 0;
    exp_first = 0;
    for (int a = 0; a < dep_of(d); a++) begin
      if (mem[d][a] != 8'(a + seed_of(d))) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end
  endtask

  // Called at a negedge; that cycle is T. Cycle T+n is observed at the n-th following negedge.
  task automatic do_run(input int d, input bit retrig, input bit chain);
    int dep, lat, fin, last_n;
    int exp_err, exp_first;
    int bad, rden_cnt, done_n, done_cnt, pass_at_done;
    dep    = dep_of(d);
    lat    = lat_of(d);
    fin    = dep + lat + 1;
    last_n = chain ? fin + 1 : fin + 5;
    model(d, exp_err, exp_first);
    bad = 0; rden_cnt = 0; done_n = -1; done_cnt = 0; pass_at_done = -1;
    wr_done[d] = 1'b1;
    for (int n = 1; n <= last_n; n++) begin
      @(negedge sys_clk);
      if (rd_en[d]) rden_cnt++;
      if (done[d]) begin
        done_cnt++;
        done_n       = n;
        pass_at_done = int'(pass[d]);
      end
      if (rd_en[d] !== (n <= dep) || busy[d] !== (n <= fin) || done[d] !== (n == fin) ||
          rd_addr[d] !== 8'((n <= dep) ? n - 1 : dep - 1))
        bad++;
      if (n == fin + 1) begin
        check($sformatf("d%0d err_cnt", d), int'(err_cnt[d]), exp_err);
        check($sformatf("d%0d first_err", d), int'(first_err_addr[d]), exp_first);
        check($sformatf("d%0d pass", d), int'(pass[d]), (exp_err == 0) ? 1 : 0);
      end
      wr_done[d] = retrig && (n == 3 || n == fin);
    end
    wr_done[d] = 1'b0;
    check($sformatf("d%0d cycle_seq", d), bad, 0);
    check($sformatf("d%0d rd_en_cycles", d), rden_cnt, dep);
    check($sformatf("d%0d done_cycle", d), done_n, fin);
    check($sformatf("d%0d done_count", d), done_cnt, 1);
    check($sformatf("d%0d pass_at_done", d), pass_at_done, 0);
  endtask

  task automatic reset_mid_run();
    int bad;
    fill_mem(0);
    mem[0][5] ^= 8'h3C;
    wr_done[0] = 1'b1;
    for (int n = 1; n <= 101; n++) begin
      @(negedge sys_clk);
      wr_done[0] = 1'b0;
    end
    check("rst addr_before", int'(rd_addr[0]), 100);
    check("rst err_before", int'(err_cnt[0]), 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("rst rd_en", int'(rd_en[0]), 0);
    check("rst busy", int'(busy[0]), 0);
    check("rst err_cnt", int'(err_cnt[0]), 0);
    check("rst pass", int'(pass[0]), 0);
    check("rst done", int'(done[0]), 0);
    check("rst first_err", int'(first_err_addr[0]), 0);
    check("rst rd_addr", int'(rd_addr[0]), 0);
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge sys_clk);
      if (done[0] || busy[0] || rd_en[0] || err_cnt[0] != 9'd0) bad++;
    end
    check("rst quiet", bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      wr_done[d] = 1'b0;
      fill_mem(d);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d reset flags", d),
            int'({rd_en[d], busy[d], done[d], pass[d]}), 0);
      check($sformatf("d%0d reset rd_addr", d), int'(rd_addr[d]), 0);
      check($sformatf("d%0d reset err_cnt", d), int'(err_cnt[d]), 0);
      check($sformatf("d%0d reset first_err", d), int'(first_err_addr[d]), 0);
    end

    // Clean full-depth sweep, then injected errors with re-triggers, chained into a clean run.
    fill_mem(0);
    do_run(0, 1'b0, 1'b0);
    mem[0][8'h10] ^= 8'h55;
    mem[0][8'hF0] ^= 8'h01;
    do_run(0, 1'b1, 1'b1);
    fill_mem(0);
    do_run(0, 1'b0, 1'b0);

    // Latency 2 with offset pattern: random corruption, then only the last word wrong.
    for (int r = 0; r < 8; r++) begin
      fill_mem(1);
      for (int a = 0; a < 16; a++)
        if ($urandom_range(0, 3) == 0) mem[1][a] ^= 8'($urandom_range(1, 255));
      do_run(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    fill_mem(1);
    mem[1][15] = 8'h00;
    do_run(1, 1'b0, 1'b0);
    fill_mem(1);
    do_run(1, 1'b1, 1'b0);

    // Single-word depth, clean and corrupted.
    fill_mem(2);
    do_run(2, 1'b0, 1'b1);
    mem[2][0] ^= 8'h80;
    do_run(2, 1'b1, 1'b0);
    mem[2][1] ^= 8'hFF;
    mem[2][0] = 8'h07;
    do_run(2, 1'b0, 1'b0);

    reset_mid_run();
    fill_mem(0);
    do_run(0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
